// File: rtl/dcache_pkg.sv
// Shared types, bus tag constants and geometry helpers for the N-way data cache.
package dcache_pkg;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WB_REQ,
        WB_DATA,
        RD_REQ,
        RD_DATA,
        FILL
    } dcache_state_e;

    function automatic int unsigned index_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned offset_bits(input int unsigned line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_width,
                                             input int unsigned sets,
                                             input int unsigned line_bytes);
        return addr_width - $clog2(sets) - $clog2(line_bytes);
    endfunction

    function automatic int unsigned way_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Replacement choice for one set: lowest invalid way, otherwise the round-robin pointer.
module dcache_victim_sel
    import dcache_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned WAY_W = 1
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [WAY_W-1:0] rr_ptr_i,
    output logic [WAY_W-1:0] victim_o
);

    logic found;

    always_comb begin
        victim_o = rr_ptr_i;
        found    = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!valid_i[i] && !found) begin
                victim_o = WAY_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with arbitrated
// system-bus access; dirty victims are written back before the line fill.
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned WAYS           = 2,
    parameter int unsigned SETS           = 512,
    parameter int unsigned LINE_BYTES     = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_active,
    input  logic                        load,
    input  logic [ADDR_WIDTH-1:0]       in_addr,
    input  logic [BUS_DATA_WIDTH-1:0]   in_data,
    input  logic [BUS_DATA_WIDTH/8-1:0] in_be,
    output logic [BUS_DATA_WIDTH-1:0]   memwb_loadeddata,
    output logic                        dataselect,
    output logic                        MEMEX_stall,
    output logic                        bus_reqcyc,
    output logic                        bus_respack,
    output logic [BUS_DATA_WIDTH-1:0]   bus_req,
    output logic [BUS_TAG_WIDTH-1:0]    bus_reqtag,
    input  logic                        bus_respcyc,
    input  logic                        bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]   bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]    bus_resptag,
    output logic                        dcache_busreq,
    output logic                        dcache_busidle,
    input  logic                        dcache_busgrant
);

    localparam int unsigned BEATS       = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int unsigned OFFSET_BITS = offset_bits(LINE_BYTES);
    localparam int unsigned INDEX_BITS  = index_bits(SETS);
    localparam int unsigned TAG_BITS    = tag_bits(ADDR_WIDTH, SETS, LINE_BYTES);
    localparam int unsigned WAY_W       = way_bits(WAYS);
    localparam int unsigned WORD_BITS   = $clog2(BUS_DATA_WIDTH / 8);
    localparam int unsigned BEAT_W      = $clog2(BEATS);
    localparam int unsigned CNT_W       = BEAT_W + 1;
    localparam int unsigned NBYTES      = BUS_DATA_WIDTH / 8;

    localparam logic [BUS_TAG_WIDTH-1:0] TAG_RD =
        {SYSBUS_READ, SYSBUS_MEMORY, {(BUS_TAG_WIDTH-5){1'b0}}};
    localparam logic [BUS_TAG_WIDTH-1:0] TAG_WR =
        {SYSBUS_WRITE, SYSBUS_MEMORY, {(BUS_TAG_WIDTH-5){1'b0}}};

    dcache_state_e              state_q;
    logic [TAG_BITS-1:0]        tag_q   [WAYS][SETS];
    logic [SETS-1:0]            valid_q [WAYS];
    logic [SETS-1:0]            dirty_q [WAYS];
    logic [WAY_W-1:0]           rr_q    [SETS];
    logic [BUS_DATA_WIDTH-1:0]  data_q  [WAYS][SETS][BEATS];

    logic [CNT_W-1:0]           cnt_q;
    logic [WAY_W-1:0]           vway_q;
    logic [INDEX_BITS-1:0]      midx_q;
    logic [TAG_BITS-1:0]        mtag_q;
    logic                       reqcyc_q;
    logic [BUS_DATA_WIDTH-1:0]  req_q;
    logic [BUS_TAG_WIDTH-1:0]   reqtag_q;
    logic                       busreq_q;
    logic                       busidle_q;

    logic [INDEX_BITS-1:0]      in_idx;
    logic [TAG_BITS-1:0]        in_tag;
    logic [BEAT_W-1:0]          in_beat;
    logic [WAYS-1:0]            set_valid;
    logic                       hit_any;
    logic [WAY_W-1:0]           hit_way;
    logic [WAY_W-1:0]           victim;
    logic                       lookup, hit, miss, store_hit;
    logic                       resp_ok;
    logic [BEAT_W-1:0]          wb_next;
    logic [ADDR_WIDTH-1:0]      miss_base;
    logic [ADDR_WIDTH-1:0]      victim_base;
    logic                       unused_addr_bits;

    assign in_idx  = in_addr[OFFSET_BITS +: INDEX_BITS];
    assign in_tag  = in_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign in_beat = in_addr[WORD_BITS +: BEAT_W];
    assign unused_addr_bits = ^in_addr[WORD_BITS-1:0];

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        set_valid = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][in_idx];
            if (valid_q[w][in_idx] && (tag_q[w][in_idx] == in_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign lookup    = mem_active && (state_q == IDLE);
    assign hit       = lookup && hit_any;
    assign miss      = lookup && !hit_any;
    assign store_hit = hit && !load;
    assign resp_ok   = (state_q == RD_DATA) && bus_respcyc && (bus_resptag == TAG_RD);
    assign wb_next   = cnt_q[BEAT_W-1:0] + 1'b1;

    assign miss_base   = {mtag_q, midx_q, OFFSET_BITS'(0)};
    assign victim_base = {tag_q[vway_q][midx_q], midx_q, OFFSET_BITS'(0)};

    dcache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_i  (set_valid),
        .rr_ptr_i (rr_q[in_idx]),
        .victim_o (victim)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            for (int unsigned w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
            cnt_q     <= '0;
            vway_q    <= '0;
            midx_q    <= '0;
            mtag_q    <= '0;
            reqcyc_q  <= 1'b0;
            req_q     <= '0;
            reqtag_q  <= '0;
            busreq_q  <= 1'b0;
            busidle_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store_hit) begin
                        dirty_q[hit_way][in_idx] <= 1'b1;
                    end
                    if (miss) begin
                        state_q  <= ARB;
                        busreq_q <= 1'b1;
                        midx_q   <= in_idx;
                        mtag_q   <= in_tag;
                        vway_q   <= victim;
                        cnt_q    <= '0;
                    end
                end
                ARB: begin
                    if (dcache_busgrant) begin
                        busreq_q  <= 1'b0;
                        busidle_q <= 1'b0;
                        reqcyc_q  <= 1'b1;
                        cnt_q     <= '0;
                        if (valid_q[vway_q][midx_q] && dirty_q[vway_q][midx_q]) begin
                            state_q  <= WB_REQ;
                            req_q    <= BUS_DATA_WIDTH'(victim_base);
                            reqtag_q <= TAG_WR;
                        end else begin
                            state_q  <= RD_REQ;
                            req_q    <= BUS_DATA_WIDTH'(miss_base);
                            reqtag_q <= TAG_RD;
                        end
                    end
                end
                WB_REQ: begin
                    if (bus_reqack) begin
                        state_q <= WB_DATA;
                        cnt_q   <= '0;
                        req_q   <= data_q[vway_q][midx_q][0];
                    end
                end
                WB_DATA: begin
                    // bus_req is registered, so each cycle preloads the following beat
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_q  <= RD_REQ;
                        cnt_q    <= '0;
                        req_q    <= BUS_DATA_WIDTH'(miss_base);
                        reqtag_q <= TAG_RD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        req_q <= data_q[vway_q][midx_q][wb_next];
                    end
                end
                RD_REQ: begin
                    if (bus_reqack) begin
                        state_q  <= RD_DATA;
                        cnt_q    <= '0;
                        reqcyc_q <= 1'b0;
                        req_q    <= '0;
                        reqtag_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (resp_ok) begin
                        if (cnt_q == CNT_W'(BEATS - 1)) begin
                            state_q <= FILL;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FILL: begin
                    tag_q[vway_q][midx_q]   <= mtag_q;
                    valid_q[vway_q][midx_q] <= 1'b1;
                    dirty_q[vway_q][midx_q] <= 1'b0;
                    rr_q[midx_q]            <= (rr_q[midx_q] == WAY_W'(WAYS - 1)) ? '0
                                                                                  : rr_q[midx_q] + 1'b1;
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    busidle_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Fill beats land directly in the victim way: the old contents are already
    // written back and the way cannot be looked up until the FSM returns to IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (store_hit) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (in_be[b]) begin
                        data_q[hit_way][in_idx][in_beat][8*b +: 8] <= in_data[8*b +: 8];
                    end
                end
            end
            if (resp_ok) begin
                data_q[vway_q][midx_q][cnt_q[BEAT_W-1:0]] <= bus_resp;
            end
        end
    end

    assign memwb_loadeddata = data_q[hit_way][in_idx][in_beat];
    assign dataselect       = hit && load;
    assign MEMEX_stall      = (state_q != IDLE) || miss;
    assign bus_respack      = resp_ok;
    assign bus_reqcyc       = reqcyc_q;
    assign bus_req          = req_q;
    assign bus_reqtag       = reqtag_q;
    assign dcache_busreq    = busreq_q;
    assign dcache_busidle   = busidle_q;

endmodule

// File: tb/tb_dcache_nway.sv
// Directed scoreboard bench for dcache_nway: cold fills, store merge, dirty
// eviction with write-back, tag-mismatched response beats and reset mid write-back.
module tb_dcache_nway;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_active;
    logic        load;
    logic [63:0] in_addr;
    logic [63:0] in_data;
    logic [7:0]  in_be;
    logic [63:0] memwb_loadeddata;
    logic        dataselect;
    logic        MEMEX_stall;
    logic        bus_reqcyc;
    logic        bus_respack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_reqack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        dcache_busreq;
    logic        dcache_busidle;
    logic        dcache_busgrant;

    localparam logic [12:0] TAG_RD = 13'h1100;
    localparam logic [12:0] TAG_WR = 13'h0100;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    bit   aborted;

    dcache_nway #(
        .ADDR_WIDTH     (64),
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .WAYS           (2),
        .SETS           (512),
        .LINE_BYTES     (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_active       (mem_active),
        .load             (load),
        .in_addr          (in_addr),
        .in_data          (in_data),
        .in_be            (in_be),
        .memwb_loadeddata (memwb_loadeddata),
        .dataselect       (dataselect),
        .MEMEX_stall      (MEMEX_stall),
        .bus_reqcyc       (bus_reqcyc),
        .bus_respack      (bus_respack),
        .bus_req          (bus_req),
        .bus_reqtag       (bus_reqtag),
        .bus_respcyc      (bus_respcyc),
        .bus_reqack       (bus_reqack),
        .bus_resp         (bus_resp),
        .bus_resptag      (bus_resptag),
        .dcache_busreq    (dcache_busreq),
        .dcache_busidle   (dcache_busidle),
        .dcache_busgrant  (dcache_busgrant)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] line_word(input logic [63:0] base, input int k);
        if (base == 64'h1000) return 64'(k + 1) * 64'h11;
        return (base << 16) | 64'(k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", obs, 64'hx);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic issue(input bit ld, input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
        @(negedge clk);
        mem_active = 1'b1;
        load       = ld;
        in_addr    = a;
        in_data    = d;
        in_be      = be;
        #1;
    endtask

    task automatic wait_load();
        int n = 0;
        while (!dataselect && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("load_dataselect", 64'(dataselect), 64'd1);
        pop_chk(memwb_loadeddata);
        chk("load_no_stall", 64'(MEMEX_stall), 64'd0);
    endtask

    task automatic serve_miss(input logic [63:0] base, input bit wb, input logic [63:0] wb_base,
                              input int bad_k, input int abort_k, output bit abrt);
        int n = 0;
        abrt = 1'b0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!dcache_busreq && n < 20);
        chk("arb_busreq", 64'(dcache_busreq), 64'd1);
        chk("arb_busidle", 64'(dcache_busidle), 64'd1);
        chk("arb_stall", 64'(MEMEX_stall), 64'd1);
        dcache_busgrant = 1'b1;
        @(negedge clk);
        dcache_busgrant = 1'b0;
        #1;
        chk("granted_busreq", 64'(dcache_busreq), 64'd0);
        chk("granted_busidle", 64'(dcache_busidle), 64'd0);
        if (wb) begin
            chk("wb_reqcyc", 64'(bus_reqcyc), 64'd1);
            chk("wb_addr", bus_req, wb_base);
            chk("wb_tag", 64'(bus_reqtag), 64'(TAG_WR));
            bus_reqack = 1'b1;
            @(negedge clk);
            bus_reqack = 1'b0;
            #1;
            for (int k = 0; k < 8; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    #1;
                end
                pop_chk(bus_req);
                chk("wb_beat_reqcyc", 64'(bus_reqcyc), 64'd1);
                if (k == abort_k) begin
                    reset = 1'b1;
                    abrt  = 1'b1;
                    return;
                end
            end
            @(negedge clk);
            #1;
        end
        chk("rd_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk("rd_addr", bus_req, base);
        chk("rd_tag", 64'(bus_reqtag), 64'(TAG_RD));
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        #1;
        chk("rd_data_reqcyc", 64'(bus_reqcyc), 64'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == bad_k) begin
                bus_respcyc = 1'b1;
                bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
                bus_resptag = TAG_WR;
                #1;
                chk("badtag_no_ack", 64'(bus_respack), 64'd0);
                @(negedge clk);
                #1;
            end
            bus_respcyc = 1'b1;
            bus_resp    = line_word(base, k);
            bus_resptag = TAG_RD;
            #1;
            chk("beat_ack", 64'(bus_respack), 64'd1);
            @(negedge clk);
            #1;
        end
        bus_respcyc = 1'b0;
        chk("fill_stall", 64'(MEMEX_stall), 64'd1);
    endtask

    initial begin
        reset           = 1'b1;
        mem_active      = 1'b0;
        load            = 1'b0;
        in_addr         = '0;
        in_data         = '0;
        in_be           = '0;
        bus_respcyc     = 1'b0;
        bus_reqack      = 1'b0;
        bus_resp        = '0;
        bus_resptag     = '0;
        dcache_busgrant = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_respack", 64'(bus_respack), 64'd0);
        chk("rst_req", bus_req, 64'd0);
        chk("rst_reqtag", 64'(bus_reqtag), 64'd0);
        chk("rst_busreq", 64'(dcache_busreq), 64'd0);
        chk("rst_busidle", 64'(dcache_busidle), 64'd1);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("inactive_stall", 64'(MEMEX_stall), 64'd0);
            chk("inactive_dataselect", 64'(dataselect), 64'd0);
            chk("inactive_busreq", 64'(dcache_busreq), 64'd0);
            chk("inactive_busidle", 64'(dcache_busidle), 64'd1);
        end

        // Cold load 0x1000 into way 0
        issue(1'b1, 64'h1000, '0, '0);
        chk("cold_miss_stall", 64'(MEMEX_stall), 64'd1);
        chk("cold_miss_dataselect", 64'(dataselect), 64'd0);
        push("cold_load_0x1000", 64'h11);
        serve_miss(64'h1000, 1'b0, '0, -1, -1, aborted);
        wait_load();

        // Partial store hit, then read back the merged word
        issue(1'b0, 64'h1008, 64'hAABB_CCDD_EEFF_0011, 8'h0F);
        chk("store_hit_stall", 64'(MEMEX_stall), 64'd0);
        chk("store_hit_dataselect", 64'(dataselect), 64'd0);
        issue(1'b1, 64'h1008, '0, '0);
        push("merged_load_0x1008", 64'h0000_0000_EEFF_0011);
        wait_load();
        chk("store_no_busreq", 64'(dcache_busreq), 64'd0);
        chk("store_no_reqcyc", 64'(bus_reqcyc), 64'd0);

        // Second line in the set goes to way 1; one response beat carries a wrong tag
        issue(1'b1, 64'h9018, '0, '0);
        push("load_0x9018", 64'h9000_0003);
        serve_miss(64'h9000, 1'b0, '0, 3, -1, aborted);
        wait_load();

        // Third line evicts dirty way 0 (0x1000): write-back then read
        push("wb_beat0", 64'h11);
        push("wb_beat1", 64'h0000_0000_EEFF_0011);
        for (int k = 2; k < 8; k++) push("wb_beat", line_word(64'h1000, k));
        issue(1'b1, 64'h11000, '0, '0);
        push("load_0x11000", 64'h1_1000_0000);
        serve_miss(64'h11000, 1'b1, 64'h1000, -1, -1, aborted);
        wait_load();

        issue(1'b1, 64'h9018, '0, '0);
        push("rehit_0x9018", 64'h9000_0003);
        wait_load();

        // Dirty 0x11000 (way 0); 0x1008 now replaces clean way 1 without write-back
        issue(1'b0, 64'h11000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        issue(1'b1, 64'h1008, '0, '0);
        push("refill_0x1008", 64'h22);
        serve_miss(64'h1000, 1'b0, '0, -1, -1, aborted);
        wait_load();

        // 0x9000 evicts dirty 0x11000; reset lands in the third write-back beat
        push("abort_wb_beat0", 64'h0123_4567_89AB_CDEF);
        push("abort_wb_beat1", 64'h1_1000_0001);
        push("abort_wb_beat2", 64'h1_1000_0002);
        issue(1'b1, 64'h9000, '0, '0);
        serve_miss(64'h9000, 1'b1, 64'h11000, -1, 2, aborted);
        chk("abort_taken", 64'(aborted), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("post_rst_busidle", 64'(dcache_busidle), 64'd1);
        chk("post_rst_busreq", 64'(dcache_busreq), 64'd0);
        in_addr = 64'h1000;
        #1;
        chk("post_rst_miss_stall", 64'(MEMEX_stall), 64'd1);
        chk("post_rst_miss_dataselect", 64'(dataselect), 64'd0);
        @(negedge clk);
        #1;
        chk("post_rst_arb_busreq", 64'(dcache_busreq), 64'd1);
        mem_active = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache between the MEM stage and the shared system bus.
- Generalises the existing 2-way data cache in several ways:
  - configurable ways, sets and line size;
  - valid bits;
  - byte-enable stores;
  - deterministic per-set round-robin replacement;
  - a sequenced dirty-victim write-back before the line fill.
- Bus access is obtained through the bus arbiter request/grant/idle handshake.

Parameters:
- ADDR_WIDTH, 64, core/bus address width.
- BUS_DATA_WIDTH, 64, bus and core data word width.
- BUS_TAG_WIDTH, 13, bus request/response tag width.
- WAYS, 2, associativity, power of 2, range 1..8.
- SETS, 512, sets per way, power of 2.
- LINE_BYTES, 64, line size in bytes. Beats per line BEATS = LINE_BYTES*8/BUS_DATA_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_active  in  1  MEM stage holds a load/store
- load  in  1  1=load, 0=store
- in_addr  in  ADDR_WIDTH  byte address, BUS_DATA_WIDTH-aligned
- in_data  in  BUS_DATA_WIDTH  store data
- in_be  in  BUS_DATA_WIDTH/8  store byte enables
- memwb_loadeddata  out  BUS_DATA_WIDTH  load result
- dataselect  out  1  load data valid this cycle
- MEMEX_stall  out  1  hold MEM/EX
- bus_reqcyc  out  1  bus request valid
- bus_respack  out  1  response beat accepted
- bus_req  out  BUS_DATA_WIDTH  address or write-data beat
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_respcyc  in  1  response beat valid
- bus_reqack  in  1  request accepted
- bus_resp  in  BUS_DATA_WIDTH  response data
- bus_resptag  in  BUS_TAG_WIDTH  response tag
- dcache_busreq  out  1  arbiter request
- dcache_busidle  out  1  cache not using bus
- dcache_busgrant  in  1  arbiter grant

Behaviour:
- Address split: offset = low log2(LINE_BYTES) bits, index = next log2(SETS) bits, tag = remainder.
- Hit = mem_active and any way with valid and tag match, while state is IDLE. Ways are unique; at most one matches.
- Reset (synchronous):
  - all valid, dirty and round-robin pointers cleared; state IDLE;
  - bus_reqcyc, bus_respack, bus_req, bus_reqtag and dcache_busreq are 0; dcache_busidle is 1.
  - Reset mid-transaction abandons the transaction with no completion (dirty data lost); bus_reqcyc is 0 the cycle after reset.
- Load hit (0 cycle):
  - memwb_loadeddata = addressed word, combinationally;
  - dataselect = 1, MEMEX_stall = 0.
- Store hit: enabled bytes merged at the clk edge; dirty set; dataselect = 0, MEMEX_stall = 0.
- mem_active = 0: MEMEX_stall = 0, dataselect = 0.
- Miss: MEMEX_stall = 1 from the miss cycle until the cycle after FILL; the access then re-evaluates as a hit.
- Victim selection: lowest-numbered invalid way, else way rr_ptr[index]. rr_ptr increments modulo WAYS on each fill of that set.
- FSM states:
  - IDLE: on miss → ARB and assert dcache_busreq.
  - ARB: on dcache_busgrant, drop dcache_busreq → WB_REQ if the victim is valid and dirty, else → RD_REQ.
  - WB_REQ:
    - drive bus_reqcyc = 1, bus_req = victim line base address;
    - bus_reqtag = {SYSBUS_WRITE,SYSBUS_MEMORY} fields;
    - hold until bus_reqack, then → WB_DATA.
  - WB_DATA: BEATS consecutive cycles with bus_reqcyc = 1, bus_req = beat k (k = 0 first, the low word), then → RD_REQ.
  - RD_REQ: drive the missing line base address with the READ tag; on bus_reqack → RD_DATA.
  - RD_DATA:
    - each bus_respcyc beat with matching bus_resptag is stored at beat counter k and acknowledged via bus_respack = 1 in that cycle;
    - non-matching beats are ignored and not acknowledged;
    - after beat BEATS-1 → FILL.
  - FILL: write line, tag, valid = 1, dirty = 0, bump rr_ptr → IDLE.
- The read request always targets the line base address; critical-word-first is not supported.
- dcache_busidle = 1 only in IDLE and ARB.
- Beat counter width is log2(BEATS)+1; it wraps to 0 on every state entry.
- Write-back precedes the fill, so no line buffer is shared between victim and fill data.

Decomposition:
- dcache_pkg:
  - SYSBUS_READ/WRITE/MEMORY tag constants;
  - dcache_state_e enum (IDLE, ARB, WB_REQ, WB_DATA, RD_REQ, RD_DATA, FILL);
  - localparam functions for INDEX_BITS, OFFSET_BITS and TAG_BITS.
- Sub-module dcache_victim_sel:
  - inputs: per-way valid vector, rr_ptr;
  - output: victim way index.

Test Plan:
- Cold load at 0x1000, WAYS=2: MEMEX_stall = 1; ARB then RD_REQ tag READ; 8 response beats 0x11..0x88 → FILL; next cycle dataselect = 1 and data = 0x11.
- Store in_data = 0xAABBCCDDEEFF0011, in_be = 0x0F to 0x1008, then load 0x1008 → 0x..EEFF0011 merged with the prior beat 0x22's upper bytes. No bus activity; dirty = 1.
- Fill three lines to one set (0x1000, 0x9000, 0x11000) with 0x1000 dirty → WB_REQ address 0x1000 and 8 write beats in order, then read of 0x11000. rr_ptr selects way 0.
- Response beat with wrong bus_resptag during RD_DATA → not acknowledged, not stored; beat counter unchanged.
- Reset asserted in cycle 3 of WB_DATA → bus_reqcyc = 0 next cycle, state IDLE, all lines invalid; the following load misses.
- mem_active = 0 throughout → MEMEX_stall = 0, dcache_busreq = 0, dcache_busidle = 1.
